// File: rtl/runner_control.sv
// runner_control: frame sequencer for the running-man game.
// Paces the floor/man/erase datapath from its finish flags and, once per
// frame, advances the man's lane, jump height and crouch style from
// debounced button edges.
// Optional feature macro: RUNNER_CROUCH_EN (crouch_key drives man_style).
module runner_control #(
  parameter int FRAME_CYCLES = 833333,
  parameter int X_POS        = 25,
  parameter int JUMP_H       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       jump_key,
  input  logic       lane_up,
  input  logic       lane_down,
  input  logic       crouch_key,
  input  logic       draw_floors_finish,
  input  logic       draw_man_finish,
  input  logic       erase_finish,
  output logic       drawing_floors,
  output logic       draw_man,
  output logic       erase,
  output logic       ld_x,
  output logic       ld_y,
  output logic       ld_man_style,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic       man_style,
  output logic [1:0] lane,
  output logic       airborne
);

  localparam int CNT_W = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [5:0] J_APEX = 6'(JUMP_H);
  localparam logic [5:0] J_TOP  = 6'(2 * JUMP_H);

  typedef enum logic [2:0] {
    S_FLOORS,
    S_LOAD,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_UPDATE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lane_q, lane_d;
  logic [5:0]       j_q, j_d;
  logic [6:0]       y_q, y_d;
  logic             style_q, style_d;
  logic             airborne_q, airborne_d;
  logic             drawing_floors_q, drawing_floors_d;
  logic             draw_man_q, draw_man_d;
  logic             erase_q, erase_d;
  logic             ld_q, ld_d;
  logic             jump_prev_q, jump_prev_d;
  logic             up_prev_q, up_prev_d;
  logic             dn_prev_q, dn_prev_d;
  logic             pend_jump_q, pend_jump_d;
  logic             pend_up_q, pend_up_d;
  logic             pend_dn_q, pend_dn_d;
  logic             jump_edge, up_edge, dn_edge;
  logic             grounded_style;

  // Lane step with saturation at the top (0) and bottom (2) lanes;
  // opposing requests in the same frame cancel.
  function automatic logic [1:0] step_lane(input logic [1:0] cur,
                                           input logic       up,
                                           input logic       dn);
    step_lane = cur;
    if (up && !dn && (cur != 2'd0))
      step_lane = cur - 2'd1;
    else if (dn && !up && (cur < 2'd2))
      step_lane = cur + 2'd1;
  endfunction

  // Top row of the man: lane base row minus the triangular jump offset.
  function automatic logic [6:0] man_row(input logic [1:0] ln,
                                         input logic [5:0] j);
    logic [5:0] off;
    logic [6:0] base;
    off  = (j <= J_APEX) ? j : (J_TOP - j);
    base = 7'd28 + (7'(ln) * 7'd40);
    man_row = base - {1'b0, off};
  endfunction

`ifdef RUNNER_CROUCH_EN
  assign grounded_style = ~crouch_key;
`else
  logic crouch_unused;
  assign crouch_unused  = crouch_key;
  assign grounded_style = 1'b1;
`endif

  assign jump_edge = jump_key  & ~jump_prev_q;
  assign up_edge   = lane_up   & ~up_prev_q;
  assign dn_edge   = lane_down & ~dn_prev_q;

  // Next-state, per-frame game update and registered output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_d     = lane_q;
    j_d        = j_q;
    y_d        = y_q;
    style_d    = style_q;

    jump_prev_d = jump_key;
    up_prev_d   = lane_up;
    dn_prev_d   = lane_down;

    // Edges seen during UPDATE belong to the next frame.
    if (state_q == S_UPDATE) begin
      pend_jump_d = jump_edge;
      pend_up_d   = up_edge;
      pend_dn_d   = dn_edge;
    end else begin
      pend_jump_d = pend_jump_q | jump_edge;
      pend_up_d   = pend_up_q   | up_edge;
      pend_dn_d   = pend_dn_q   | dn_edge;
    end

    case (state_q)
      S_FLOORS: if (draw_floors_finish) state_d = S_LOAD;
      S_LOAD:   state_d = S_DRAW;
      S_DRAW: begin
        if (draw_man_finish) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = S_ERASE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_ERASE:  if (erase_finish) state_d = S_UPDATE;
      S_UPDATE: begin
        state_d = S_LOAD;
        if (j_q != 6'd0) begin
          // Mid-jump: follow the arc, ignore requests, stay upright.
          j_d     = (j_q == J_TOP - 6'd1) ? 6'd0 : (j_q + 6'd1);
          style_d = 1'b1;
        end else begin
          lane_d = step_lane(lane_q, pend_up_q, pend_dn_q);
          if (pend_jump_q) begin
            j_d     = 6'd1;
            style_d = 1'b1;
          end else begin
            style_d = grounded_style;
          end
        end
        y_d = man_row(lane_d, j_d);
      end
      default: state_d = S_FLOORS;
    endcase

    airborne_d       = (j_d != 6'd0);
    drawing_floors_d = (state_d == S_FLOORS);
    ld_d             = (state_d == S_LOAD);
    draw_man_d       = (state_d == S_DRAW);
    erase_d          = (state_d == S_ERASE);
  end

  // State, game registers and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_FLOORS;
      cnt_q            <= '0;
      lane_q           <= 2'd0;
      j_q              <= 6'd0;
      y_q              <= 7'd28;
      style_q          <= 1'b1;
      airborne_q       <= 1'b0;
      drawing_floors_q <= 1'b0;
      draw_man_q       <= 1'b0;
      erase_q          <= 1'b0;
      ld_q             <= 1'b0;
      jump_prev_q      <= 1'b1;
      up_prev_q        <= 1'b1;
      dn_prev_q        <= 1'b1;
      pend_jump_q      <= 1'b0;
      pend_up_q        <= 1'b0;
      pend_dn_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      lane_q           <= lane_d;
      j_q              <= j_d;
      y_q              <= y_d;
      style_q          <= style_d;
      airborne_q       <= airborne_d;
      drawing_floors_q <= drawing_floors_d;
      draw_man_q       <= draw_man_d;
      erase_q          <= erase_d;
      ld_q             <= ld_d;
      jump_prev_q      <= jump_prev_d;
      up_prev_q        <= up_prev_d;
      dn_prev_q        <= dn_prev_d;
      pend_jump_q      <= pend_jump_d;
      pend_up_q        <= pend_up_d;
      pend_dn_q        <= pend_dn_d;
    end
  end

  assign drawing_floors = drawing_floors_q;
  assign draw_man       = draw_man_q;
  assign erase          = erase_q;
  assign ld_x           = ld_q;
  assign ld_y           = ld_q;
  assign ld_man_style   = ld_q;
  assign x_out          = 8'(X_POS);
  assign y_out          = y_q;
  assign man_style      = style_q;
  assign lane           = lane_q;
  assign airborne       = airborne_q;

endmodule

// File: tb/tb_runner_control.sv
// Scoreboard bench for runner_control: a frame-level game model pushes the
// expected man state for every LOAD; a monitor pops it when LOAD appears.
module tb_runner_control;

  localparam int FC = 4;
  localparam int JH = 3;
`ifdef RUNNER_CROUCH_EN
  localparam bit CROUCH_EN = 1'b1;
`else
  localparam bit CROUCH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic jump_key = 1'b0, lane_up = 1'b0, lane_down = 1'b0, crouch_key = 1'b0;
  logic draw_floors_finish = 1'b0, draw_man_finish = 1'b0, erase_finish = 1'b0;
  logic drawing_floors, draw_man, erase, ld_x, ld_y, ld_man_style;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic man_style, airborne;
  logic [1:0] lane;

  runner_control #(.FRAME_CYCLES(FC), .X_POS(25), .JUMP_H(JH)) dut (
    .clk(clk), .reset(reset),
    .jump_key(jump_key), .lane_up(lane_up), .lane_down(lane_down),
    .crouch_key(crouch_key),
    .draw_floors_finish(draw_floors_finish), .draw_man_finish(draw_man_finish),
    .erase_finish(erase_finish),
    .drawing_floors(drawing_floors), .draw_man(draw_man), .erase(erase),
    .ld_x(ld_x), .ld_y(ld_y), .ld_man_style(ld_man_style),
    .x_out(x_out), .y_out(y_out), .man_style(man_style), .lane(lane),
    .airborne(airborne)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur", name);
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef struct packed {
    logic [6:0] y;
    logic       style;
    logic [1:0] ln;
    logic       air;
  } exp_t;

  exp_t exp_q[$];
  int   m_lane = 0;
  int   m_off  = 0;
  bit   m_style = 1'b1;
  int   traj[$];   // remaining jump offsets, one per future frame

  task automatic model_push();
    exp_t e;
    e.y     = 7'(28 + 40 * m_lane - m_off);
    e.style = m_style;
    e.ln    = 2'(m_lane);
    e.air   = (traj.size() != 0);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    traj.delete();
    m_lane = 0; m_off = 0; m_style = 1'b1;
    model_push();
  endtask

  task automatic model_update(input bit j, input bit u, input bit d, input bit c);
    if (traj.size() != 0) begin
      m_off   = traj.pop_front();
      m_style = 1'b1;
    end else begin
      if (u && !d)      m_lane = (m_lane > 0) ? m_lane - 1 : 0;
      else if (d && !u) m_lane = (m_lane < 2) ? m_lane + 1 : 2;
      if (j) begin
        m_off = 1;
        for (int h = 2; h <= JH; h++)     traj.push_back(h);
        for (int h = JH - 1; h >= 0; h--) traj.push_back(h);
        m_style = 1'b1;
      end else begin
        m_off   = 0;
        m_style = CROUCH_EN ? !c : 1'b1;
      end
    end
    model_push();
  endtask

  // ---------------- monitor ----------------
  exp_t e_mon;
  logic [6:0] last_y = 7'd28;
  logic last_style = 1'b1;
  logic erase_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ld_x || ld_y || ld_man_style) begin
        chk("ld_strobes", {ld_x, ld_y, ld_man_style}, 3'b111);
        if (exp_q.size() == 0) fail_now("load_expectation");
        else begin
          e_mon = exp_q.pop_front();
          chk("load_y", y_out, e_mon.y);
          chk("load_style", man_style, e_mon.style);
          chk("load_lane", lane, e_mon.ln);
          chk("load_airborne", airborne, e_mon.air);
          chk("load_x", x_out, 25);
        end
        last_y = y_out;
        last_style = man_style;
      end
      if (erase && !erase_prev) begin
        chk("erase_y_stable", y_out, last_y);
        chk("erase_style_stable", man_style, last_style);
      end
      erase_prev = erase;
    end else begin
      erase_prev = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic floors_seq();
    int hi;
    @(negedge clk);
    reset = 1'b0;
    chk("floors_idle_after_reset", drawing_floors, 0);
    hi = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      hi += int'(drawing_floors);
      if (k == 10) draw_floors_finish = 1'b1;
    end
    @(posedge clk); #1;
    draw_floors_finish = 1'b0;
    chk("floors_drop", drawing_floors, 0);
    chk("floors_len", hi, 10);
  endtask

  task automatic run_frame(input bit j, input bit u, input bit d, input bit c,
                           input int dly, input int edly, input bit rst_mid);
    int n;
    n = 0;
    while (!draw_man && n < 20) begin @(posedge clk); #1; n++; end
    if (!draw_man) fail_now("draw_man_start");
    crouch_key = c;
    jump_key = j; lane_up = u; lane_down = d;
    @(posedge clk); #1;
    jump_key = 1'b0; lane_up = 1'b0; lane_down = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    draw_man_finish = 1'b1;
    @(posedge clk); #1;
    draw_man_finish = 1'b0;
    chk("draw_man_drop", draw_man, 0);
    n = 0;
    while (!erase && n < 20) begin @(posedge clk); #1; n++; end
    chk("wait_len", n, FC);
    if (rst_mid) begin
      #2 reset = 1'b1;
      #1;
      chk("reset_outputs",
          {drawing_floors, draw_man, erase, ld_x, ld_y, ld_man_style,
           airborne, man_style, lane, y_out, x_out},
          {6'b0, 1'b0, 1'b1, 2'd0, 7'd28, 8'd25});
      model_reset();
      floors_seq();
      return;
    end
    repeat (edly) begin @(posedge clk); #1; end
    erase_finish = 1'b1;
    model_update(j, u, d, c);
    @(posedge clk); #1;
    erase_finish = 1'b0;
    chk("erase_drop", erase, 0);
  endtask

  // Directed frames: {jump, up, down, crouch}
  logic [3:0] dir_tab [0:18] = '{
    4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000,
    4'b0010, 4'b0010, 4'b0010, 4'b0110, 4'b0100,
    4'b0001, 4'b1001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
    4'b0001, 4'b0001
  };

  initial begin
    logic [3:0] f;
    #12;
    chk("reset_drawing_floors", drawing_floors, 0);
    chk("reset_y", y_out, 28);
    chk("reset_style", man_style, 1);
    model_reset();
    floors_seq();
    for (int i = 0; i < 19; i++) begin
      f = dir_tab[i];
      run_frame(f[3], f[2], f[1], f[0], 1 + (i % 3), i % 2, 1'b0);
    end
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, 2, 1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      run_frame(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 5), $urandom_range(0, 4), 1'b0);
    end
    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
